// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI master.
//   state_t : transfer FSM states
//   MODEx   : SPI mode encodings as {cpol, cpha}
//   cfg_t   : per-transfer configuration latched on start
//   clog2   : ceil(log2(n)), never below 1, for counter/select widths
package spi_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef struct packed {
    logic [1:0] mode;       // {cpol, cpha}
    logic       lsb_first;
  } cfg_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/spi_master_param_clkgen.sv
// SCLK timing generator.
//   clk, reset : system clock, synchronous active-high reset
//   en         : FSM is outside IDLE; the divider runs only while set
//   setup/xfer : FSM is in SETUP / XFER
//   tick       : last clk cycle of the current CLK_DIV-long period
//   lead_stb   : SCLK must toggle to its leading (active) level this edge
//   trail_stb  : SCLK must toggle back to its idle level this edge
//   last_edge  : trail_stb of the final trailing edge of the word
//   xfer_done  : final XFER half-period ends on this edge
module spi_clkgen
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic setup,
  input  logic xfer,
  output logic tick,
  output logic lead_stb,
  output logic trail_stb,
  output logic last_edge,
  output logic xfer_done
);

  localparam int DW   = clog2(CLK_DIV);
  localparam int HW   = clog2(2 * DATA_W) + 1;
  localparam int LAST = 2 * DATA_W - 1;

  logic [DW-1:0] div_cnt;
  logic [HW-1:0] half_cnt;
  logic          more;

  always_ff @(posedge clk) begin
    if (reset || !en || tick) div_cnt <= '0;
    else                      div_cnt <= div_cnt + 1'b1;

    if (reset || !xfer) half_cnt <= '0;
    else if (tick)      half_cnt <= half_cnt + 1'b1;
  end

  assign tick = en && (div_cnt == DW'(CLK_DIV - 1));

  // The edge ending half-period h starts half-period h+1, i.e. toggle h+2.
  // Toggle 1 (leading) is issued by the end of SETUP; the end of the last
  // half-period issues no toggle and moves the FSM to HOLD.
  assign more      = half_cnt < HW'(LAST);
  assign lead_stb  = tick && (setup || (xfer && half_cnt[0] && more));
  assign trail_stb = tick && xfer && !half_cnt[0] && more;
  assign last_edge = trail_stb && (half_cnt == HW'(LAST - 1));
  assign xfer_done = tick && xfer && !more;

endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master.
//   clk, reset          : system clock, synchronous active-high reset
//   start               : transfer request, honoured only while !busy
//   din, ss_sel         : word and slave index, latched on accept
//   cpol, cpha          : SPI mode, latched on accept
//   lsb_first           : bit order, latched on accept
//   miso                : serial input (sampled directly in clk domain)
//   mosi, sclk, ss_n    : SPI bus outputs (ss_n active low)
//   dout                : last received word, updated with done
//   busy                : transfer in progress
//   done                : one-cycle end-of-transfer pulse
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2,
  parameter int NUM_SS  = 4,
  parameter int SEL_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic              miso,
  output logic              mosi,
  output logic              sclk,
  output logic [NUM_SS-1:0] ss_n,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done
);

  state_t            state, state_nxt;
  cfg_t              cfg_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] tx_sh, rx_sh, tx_nxt;
  logic              tick, lead_stb, trail_stb, last_edge, xfer_done;
  logic              accept, cpha_q, samp_stb, shift_stb;

  spi_clkgen #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) u_clkgen (
    .clk       (clk),
    .reset     (reset),
    .en        (state != IDLE),
    .setup     (state == SETUP),
    .xfer      (state == XFER),
    .tick      (tick),
    .lead_stb  (lead_stb),
    .trail_stb (trail_stb),
    .last_edge (last_edge),
    .xfer_done (xfer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE:    if (start) begin state_nxt = SETUP; accept = 1'b1; end
      SETUP:   if (tick) state_nxt = XFER;
      XFER:    if (xfer_done) state_nxt = HOLD;
      HOLD:    if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cpha_q = (cfg_q.mode == MODE1) || (cfg_q.mode == MODE3);

  // cpha=0: sample on leading, shift on trailing (none after the last one).
  // cpha=1: sample on trailing, shift on leading; the SETUP leading edge is
  // skipped because the first bit was already driven at accept.
  assign samp_stb  = cpha_q ? trail_stb : lead_stb;
  assign shift_stb = cpha_q ? (lead_stb && state == XFER)
                            : (trail_stb && !last_edge);
  assign tx_nxt    = cfg_q.lsb_first ? (tx_sh >> 1) : (tx_sh << 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q <= '0;
      sel_q <= '0;
      tx_sh <= '0;
      rx_sh <= '0;
      mosi  <= 1'b0;
      sclk  <= 1'b0;
      dout  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        cfg_q <= '{mode: {cpol, cpha}, lsb_first: lsb_first};
        sel_q <= ss_sel;
        tx_sh <= din;
        rx_sh <= '0;
        mosi  <= lsb_first ? din[0] : din[DATA_W-1];
        sclk  <= cpol;
      end else begin
        if (lead_stb || trail_stb) sclk <= ~sclk;
        else if (state == IDLE)    sclk <= cfg_q.mode[1];
        if (shift_stb) begin
          tx_sh <= tx_nxt;
          mosi  <= cfg_q.lsb_first ? tx_nxt[0] : tx_nxt[DATA_W-1];
        end
        if (samp_stb)
          rx_sh <= cfg_q.lsb_first ? {miso, rx_sh[DATA_W-1:1]}
                                   : {rx_sh[DATA_W-2:0], miso};
        if (state == HOLD && tick) begin
          done <= 1'b1;
          dout <= rx_sh;
        end
      end
    end
  end

  assign busy = (state != IDLE);

  // Out-of-range selects simply match no line.
  for (genvar i = 0; i < NUM_SS; i++) begin : g_ss
    assign ss_n[i] = !(busy && (sel_q == SEL_W'(i)));
  end

endmodule
